comp_serial: RTL and testbench
==============================

# comp_serial

Serial N-bit word comparator that extends the team's single-bit equality comparison (eq = a·b + a'·b') to whole words delivered one bit per cycle. Two operands arrive MSB-first on `a` and `b` under a `bit_valid` qualifier. After N qualified bits, the block reports equal, greater or less on registered flags with a one-cycle `done` pulse. It is the receiving/checking end of any serial link that ships operand bits: the datapath shifts words out, and this block consumes and judges them.

## Interface
- `N`, default 8: operand width in bits; legal range N ≥ 1.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `start`  in  1: begins a new comparison; accepted in any state.
- `bit_valid`  in  1: `a` and `b` carry a valid bit pair this cycle.
- `a`  in  1: operand A serial bit, MSB first.
- `b`  in  1: operand B serial bit, MSB first.
- `busy`  out  1: comparison in progress.
- `done`  out  1: one-cycle pulse; result flags valid from this cycle.
- `eq`  out  1: A == B.
- `gt`  out  1: A > B (unsigned).
- `lt`  out  1: A < B (unsigned).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: waits for `start`.
- RUN: counts qualified bits.
- DONE: lasts one cycle, then returns to IDLE unless `start` is high.
- `start` high in any state:
  - next state is RUN;
  - bit counter is cleared (width clog2(N+1));
  - decided flag and provisional result are cleared;
  - `eq`/`gt`/`lt` are cleared to 0.
- `start` and `bit_valid` high in the same cycle: `start` wins and that bit pair is discarded.
- RUN with `bit_valid`=1:
  - per-bit equality is a·b + a'·b';
  - if the pair is unequal and nothing is decided yet, latch gt = a & ~b, lt = ~a & b, and set decided;
  - later bits never change a decided result;
  - the counter increments.
- RUN with `bit_valid`=0: hold all state. Gaps of any length are allowed.
- On the Nth qualified bit:
  - transition to DONE;
  - eq = ~decided (including the current bit);
  - gt and lt take their latched values.
- Exactly one of `eq`/`gt`/`lt` is 1 from DONE onward. All three are 0 during RUN and after reset.
- Results hold through IDLE until the next `start` is accepted.
- `bit_valid` is ignored in IDLE and DONE.
- Reset asserted at any time, including mid-RUN:
  - immediately state = IDLE and counter = 0;
  - `busy`=`done`=`eq`=`gt`=`lt`=0;
  - the partial comparison is lost.

## Timing
- Reset values: all outputs 0; state IDLE.
- `start` is sampled at edge t0. `busy`=1 from after t0; the first bit is sampled at edge t0+1 at the earliest.
- The Nth qualified bit is sampled at edge tN:
  - `done`=1 and the flags are valid from after tN;
  - `busy` falls at tN, so `busy` and `done` are never high together.
- Minimum latency from `start` to `done`: N+1 cycles, with `bit_valid` held high.
- `done` is exactly one cycle wide, unless `start` arrives in the DONE cycle. In that case `done` still lasts one cycle and the flags clear at the following edge.
- Back-to-back operation: `start` may be asserted in the DONE cycle. Throughput is N+1 cycles per comparison.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- N=8, A=0xA5, B=0xA5, `bit_valid` continuous after `start` → `done` pulses at cycle 9 with eq=1, gt=0, lt=0; `busy` high for cycles 1–8.
- N=8, A=0x80, B=0x7F → gt=1, lt=0, eq=0 at `done`. Decided on the first bit, yet `done` still arrives only after 8 bits.
- N=8, A=0x3C, B=0x3D with `bit_valid` toggling 1,0,1,0… → lt=1. `done` arrives after the 8th valid bit (≈16 cycles); invalid-cycle bits are ignored.
- N=8, restart: A=0xFF vs B=0x00 for 4 bits, then `start` together with `bit_valid`, then A=0x12 vs B=0x12 → eq=1. No `done` for the aborted run; the bit in the `start` cycle is discarded.
- N=8, `rstn` pulsed low after 5 bits → all outputs 0 asynchronously. A new `start` with A=0x01, B=0x02 gives lt=1 after 8 bits.
- N=1: A=1, B=0 → gt=1, `done` 2 cycles after `start`. Then `start` in the DONE cycle with A=0, B=0 → eq=1 two cycles later.

Source files
------------

// File: rtl/comp_serial.sv
// Serial MSB-first unsigned comparator: judges two N-bit words delivered one bit pair per qualified cycle.
// Latency N+1 cycles from start to done; bit_valid gaps stall the count; start restarts from any state.
module comp_serial #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic bit_valid,
  input  logic a,
  input  logic b,
  output logic busy,
  output logic done,
  output logic eq,
  output logic gt,
  output logic lt
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          decided_q, decided_d;
  logic          gt_p_q, gt_p_d;
  logic          lt_p_q, lt_p_d;
  logic          eq_q, eq_d;
  logic          gt_q, gt_d;
  logic          lt_q, lt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_eq;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    gt_p_d    = gt_p_q;
    lt_p_d    = lt_p_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    bit_eq    = (a & b) | (~a & ~b);

    if (start) begin
      // start wins over a coincident bit pair, which is dropped
      state_d   = RUN;
      cnt_d     = '0;
      decided_d = 1'b0;
      gt_p_d    = 1'b0;
      lt_p_d    = 1'b0;
      eq_d      = 1'b0;
      gt_d      = 1'b0;
      lt_d      = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bit_valid) begin
            // first differing bit (MSB-first) fixes the ordering for good
            if (!decided_q && !bit_eq) begin
              gt_p_d    = a & ~b;
              lt_p_d    = ~a & b;
              decided_d = 1'b1;
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              state_d = DONE;
              eq_d    = ~decided_d;
              gt_d    = gt_p_d;
              lt_d    = lt_p_d;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      gt_p_q    <= 1'b0;
      lt_p_q    <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      gt_p_q    <= gt_p_d;
      lt_p_q    <= lt_p_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_comp_serial.sv
// Directed bench for comp_serial at N=8 and N=1; expected {eq,gt,lt} queued at start, checked on done.
module tb_comp_serial;

  logic clk = 1'b0;
  logic rstn;
  logic s8, v8, a8, b8, busy8, done8, eq8, gt8, lt8;
  logic s1, v1, a1, b1, busy1, done1, eq1, gt1, lt1;

  int checks = 0;
  int errors = 0;
  logic [2:0] q8[$];
  logic [2:0] q1[$];

  always #5 clk = ~clk;

  comp_serial #(.N(8)) u8 (
    .clk(clk), .rstn(rstn), .start(s8), .bit_valid(v8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .eq(eq8), .gt(gt8), .lt(lt8)
  );

  comp_serial #(.N(1)) u1 (
    .clk(clk), .rstn(rstn), .start(s1), .bit_valid(v1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [7:0] x, input logic [7:0] y);
    return {x == y, x > y, x < y};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rstn === 1'b1 && done8 === 1'b1) begin
      if (q8.size() == 0) chk("n8_unexpected_done", 8'(done8), 8'd0);
      else chk("n8_flags_at_done", 8'({eq8, gt8, lt8}), 8'(q8.pop_front()));
    end
    if (rstn === 1'b1 && done1 === 1'b1) begin
      if (q1.size() == 0) chk("n1_unexpected_done", 8'(done1), 8'd0);
      else chk("n1_flags_at_done", 8'({eq1, gt1, lt1}), 8'(q1.pop_front()));
    end
  end

  task automatic run8(input logic [7:0] A, input logic [7:0] B, input bit gappy, input bit bit_in_start);
    logic [2:0] exp;
    exp = model(A, B);
    s8 = 1'b1;
    v8 = bit_in_start;
    a8 = 1'b1;
    b8 = 1'b0;
    step();
    s8 = 1'b0;
    v8 = 1'b0;
    chk("busy_after_start", 8'(busy8), 8'd1);
    chk("flags_cleared_by_start", 8'({eq8, gt8, lt8}), 8'd0);
    q8.push_back(exp);
    for (int i = 7; i >= 0; i--) begin
      if (gappy) begin
        v8 = 1'b0;
        a8 = ~A[i];
        b8 = ~B[i];
        step();
      end
      v8 = 1'b1;
      a8 = A[i];
      b8 = B[i];
      step();
      if (i > 0) chk("no_early_done", 8'({done8, busy8}), 8'b01);
    end
    v8 = 1'b0;
    chk("done_pulse", 8'({done8, busy8}), 8'b10);
    step();
    chk("done_one_cycle", 8'(done8), 8'd0);
    chk("flags_hold_idle", 8'({eq8, gt8, lt8}), 8'(exp));
  endtask

  initial begin
    rstn = 1'b0;
    {s8, v8, a8, b8} = '0;
    {s1, v1, a1, b1} = '0;
    #3;
    chk("reset_outputs_n8", 8'({busy8, done8, eq8, gt8, lt8}), 8'd0);
    chk("reset_outputs_n1", 8'({busy1, done1, eq1, gt1, lt1}), 8'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    run8(8'hA5, 8'hA5, 1'b0, 1'b0);
    run8(8'h80, 8'h7F, 1'b0, 1'b0);
    run8(8'h3C, 8'h3D, 1'b1, 1'b0);

    // aborted run: no expectation queued, then restart with a bit in the start cycle
    s8 = 1'b1;
    step();
    s8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v8 = 1'b1;
      a8 = 1'b1;
      b8 = 1'b0;
      step();
    end
    run8(8'h12, 8'h12, 1'b0, 1'b1);

    // asynchronous reset in the middle of a run
    s8 = 1'b1;
    step();
    s8 = 1'b0;
    for (int i = 7; i >= 3; i--) begin
      v8 = 1'b1;
      a8 = 1'(8'h01 >> i);
      b8 = 1'(8'h02 >> i);
      step();
    end
    v8 = 1'b0;
    chk("busy_before_reset", 8'(busy8), 8'd1);
    rstn = 1'b0;
    #1;
    chk("async_reset_clears", 8'({busy8, done8, eq8, gt8, lt8}), 8'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();
    run8(8'h01, 8'h02, 1'b0, 1'b0);

    // N=1, then back-to-back start during the DONE cycle
    s1 = 1'b1;
    step();
    s1 = 1'b0;
    chk("n1_busy_after_start", 8'(busy1), 8'd1);
    q1.push_back(3'b010);
    v1 = 1'b1;
    a1 = 1'b1;
    b1 = 1'b0;
    step();
    v1 = 1'b0;
    chk("n1_done_two_cycles", 8'({done1, busy1}), 8'b10);
    s1 = 1'b1;
    step();
    s1 = 1'b0;
    chk("n1_restart_in_done", 8'({done1, busy1, eq1, gt1, lt1}), 8'b01000);
    q1.push_back(3'b100);
    v1 = 1'b1;
    a1 = 1'b0;
    b1 = 1'b0;
    step();
    v1 = 1'b0;
    chk("n1_second_done", 8'({done1, busy1}), 8'b10);
    step();
    chk("n1_eq_hold", 8'({done1, eq1, gt1, lt1}), 8'b0100);

    chk("n8_queue_drained", 8'(q8.size()), 8'd0);
    chk("n1_queue_drained", 8'(q1.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
